// File: rtl/complex_remul_if.sv
// complex_remul_if: sample/ratio bus for the complex re-multiplier.
// The master drives the ratio, sample, strobe and enable; the slave (the
// multiplier) returns the rounded product, its strobe and the overflow flag.
interface complex_remul_if;
    logic               enable;
    logic signed [31:0] p_i;
    logic signed [31:0] p_q;
    logic signed [15:0] b_i;
    logic signed [15:0] b_q;
    logic               input_strobe;
    logic signed [15:0] a_i;
    logic signed [15:0] a_q;
    logic               output_strobe;
    logic               overflow;

    modport master (
        output enable, p_i, p_q, b_i, b_q, input_strobe,
        input  a_i, a_q, output_strobe, overflow
    );

    modport slave (
        input  enable, p_i, p_q, b_i, b_q, input_strobe,
        output a_i, a_q, output_strobe, overflow
    );
endinterface

// File: rtl/complex_remul.sv
// complex_remul: a = p * b, with p a 32-bit fixed-point complex ratio
// (FRAC_BITS fractional bits) and b a 16-bit complex sample. Four-stage
// pipeline: register inputs, partial products, combine, round and narrow.
// Optional feature macro: COMPLEX_REMUL_SATURATE_EN selects clamping of the
// narrowed result (with an overflow flag); without it the result wraps and
// overflow stays 0.
module complex_remul #(
    parameter int FRAC_BITS = 8,
    parameter int LATENCY   = 4
) (
    input logic            clock,
    input logic            reset,
    complex_remul_if.slave bus
);

    localparam logic signed [48:0] ROUND_HALF = 49'sd1 <<< (FRAC_BITS - 1);
`ifdef COMPLEX_REMUL_SATURATE_EN
    localparam logic signed [48:0] MAX_OUT = 49'sd32767;
    localparam logic signed [48:0] MIN_OUT = -49'sd32768;
`endif

    logic signed [31:0] p_i_s1, p_q_s1;
    logic signed [15:0] b_i_s1, b_q_s1;
    logic signed [47:0] ii_s2, qq_s2, iq_s2, qi_s2;
    logic signed [48:0] re_s3, im_s3;
    logic signed [15:0] a_i_r, a_q_r;
    logic               overflow_r;
    logic [LATENCY-1:0] strobe_pipe;
    logic [16:0]        narrow_re, narrow_im;

    // Round half-up, drop the fraction and narrow to 16 bits.
    // Bit 16 of the result reports that the value had to be clamped.
    function automatic logic [16:0] narrow(input logic signed [48:0] acc);
`ifdef COMPLEX_REMUL_SATURATE_EN
        logic signed [48:0] rounded;
        rounded = (acc + ROUND_HALF) >>> FRAC_BITS;
        if (rounded > MAX_OUT) begin
            return {1'b1, 16'h7FFF};
        end else if (rounded < MIN_OUT) begin
            return {1'b1, 16'h8000};
        end else begin
            return {1'b0, rounded[15:0]};
        end
`else
        return {1'b0, 16'((acc + ROUND_HALF) >>> FRAC_BITS)};
`endif
    endfunction

    assign narrow_re = narrow(re_s3);
    assign narrow_im = narrow(im_s3);

    // Stage 1: capture ratio and sample.
    always_ff @(posedge clock) begin
        if (reset) begin
            p_i_s1 <= '0;
            p_q_s1 <= '0;
            b_i_s1 <= '0;
            b_q_s1 <= '0;
        end else if (bus.enable) begin
            p_i_s1 <= bus.p_i;
            p_q_s1 <= bus.p_q;
            b_i_s1 <= bus.b_i;
            b_q_s1 <= bus.b_q;
        end
    end

    // Stage 2: four full-width signed partial products, no truncation.
    always_ff @(posedge clock) begin
        if (reset) begin
            ii_s2 <= '0;
            qq_s2 <= '0;
            iq_s2 <= '0;
            qi_s2 <= '0;
        end else if (bus.enable) begin
            ii_s2 <= 48'(p_i_s1) * 48'(b_i_s1);
            qq_s2 <= 48'(p_q_s1) * 48'(b_q_s1);
            iq_s2 <= 48'(p_i_s1) * 48'(b_q_s1);
            qi_s2 <= 48'(p_q_s1) * 48'(b_i_s1);
        end
    end

    // Stage 3: combine into real and imaginary parts with one guard bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            re_s3 <= '0;
            im_s3 <= '0;
        end else if (bus.enable) begin
            re_s3 <= 49'(ii_s2) - 49'(qq_s2);
            im_s3 <= 49'(iq_s2) + 49'(qi_s2);
        end
    end

    // Stage 4: register the rounded, narrowed result and its overflow flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_i_r      <= '0;
            a_q_r      <= '0;
            overflow_r <= 1'b0;
        end else if (bus.enable) begin
            a_i_r      <= narrow_re[15:0];
            a_q_r      <= narrow_im[15:0];
            overflow_r <= narrow_re[16] | narrow_im[16];
        end
    end

    // Strobe delay line running alongside the data; LATENCY must stay 4.
    always_ff @(posedge clock) begin
        if (reset) begin
            strobe_pipe <= '0;
        end else if (bus.enable) begin
            strobe_pipe <= {strobe_pipe[LATENCY-2:0], bus.input_strobe};
        end
    end

    assign bus.a_i           = a_i_r;
    assign bus.a_q           = a_q_r;
    assign bus.overflow      = overflow_r;
    assign bus.output_strobe = strobe_pipe[LATENCY-1];

endmodule

// File: doc/complex_remul.md
Name: complex_remul

Overview:
- Re-applies a complex ratio to a reference sample: a = p * b.
- p is the 32-bit fixed-point quotient produced by the CSI/channel-ratio divider path, with FRAC_BITS fractional bits. b is a 16-bit complex sample. The result is a 16-bit complex sample.
- Sits downstream of the ratio divider. It re-applies stored channel ratios to pilot/reference symbols and is the inverse operation of the complex divide.
- Fully pipelined: one sample per clock, fixed latency.

Parameters:
- FRAC_BITS, 8, number of fractional bits in p_i/p_q (256 = 1.0).
- LATENCY, 4, pipeline depth in enabled cycles. Fixed and informational only; the implementation must match it.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  pipeline advance; low freezes every register
- p_i  input  32  ratio real part, signed two's complement, FRAC_BITS fractional
- p_q  input  32  ratio imaginary part, signed
- b_i  input  16  sample real part, signed
- b_q  input  16  sample imaginary part, signed
- input_strobe  input  1  p/b valid this cycle
- a_i  output  16  result real part, signed
- a_q  output  16  result imaginary part, signed
- output_strobe  output  1  a_i/a_q valid this cycle
- overflow  output  1  saturation occurred on this output sample

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high, sampled on posedge clock, and takes priority over enable.
- On reset, all pipeline registers clear to 0: a_i=0, a_q=0, output_strobe=0, overflow=0.
- Stage 1 (register inputs): register p_i, p_q, b_i, b_q and input_strobe.
- Stage 2 (partial products): compute four signed 48-bit products: pi*bi, pq*bq, pi*bq, pq*bi.
- Stage 3 (combine): re = pi*bi - pq*bq; im = pi*bq + pq*bi. Both are 49-bit signed and must not overflow internally.
- Stage 4 (round and narrow):
  - Add 2^(FRAC_BITS-1), then arithmetic shift right by FRAC_BITS. This is round-half-up (toward +inf on ties).
  - Narrow to 16 bits (see Optional Feature).
  - Register the results into a_i, a_q and overflow.
- Latency: the strobe travels in parallel with the data through 4 registers. output_strobe rises exactly 4 enabled cycles after input_strobe.
- Throughput: back-to-back strobes are accepted every cycle; there are no bubbles or backpressure.
- enable=0: every register, strobe included, holds its value. Outputs stay constant, and output_strobe stays at its held level. The bench treats a held strobe as one sample.
- Idle data: data moves through the pipeline regardless of input_strobe. Outputs are only meaningful when output_strobe=1.
- Reset mid-stream: all in-flight samples are discarded. No output_strobe occurs until 4 enabled cycles after the next input_strobe following reset release.
- Boundary: p = -2^31 and b = -32768 are legal. Products must use full signed width with no truncation before stage 4.

Optional Feature:
- Macro: COMPLEX_REMUL_SATURATE_EN.
- Defined:
  - If the rounded value exceeds 32767, clamp to 32767; if it is below -32768, clamp to -32768.
  - overflow=1 for the sample if either component clamped, else 0.
- Undefined:
  - Output the low 16 bits of the rounded value (wrap).
  - overflow is tied to 0.
  - Stage 4 saturation logic is removed.

Test Plan:
- Unity ratio: p=(256,0), b=(100,-50), strobe 1 cycle -> 4 cycles later a=(100,-50), output_strobe high for exactly 1 cycle, overflow=0.
- Rotation: p=(0,256) (j), b=(100,50) -> a=(-50,100).
- Rounding, positive and negative ties:
  - p=(384,0) (1.5), b=(3,0) -> a_i=5 (4.5 rounds up).
  - Same p, b=(-3,0) -> a_i=-4.
- Saturation: p=(0x7FFFFFFF,0), b=(32767,0):
  - With macro: a_i=32767, overflow=1.
  - Without macro: a_i = bits [15:0] of ((p*b+128)>>>8), overflow=0.
- Streaming and stall: 8 consecutive strobes with distinct ratios, enable low for 3 cycles mid-burst -> 8 outputs in order. Each output equals the golden model, and the output stream freezes during the stall.
- Reset mid-operation: 2 strobes issued, reset asserted 2 cycles later for 1 cycle -> all outputs 0, no output_strobe afterwards until a new input_strobe plus 4 cycles.
